// File: rtl/oflow_calc_iou.sv
// oflow_calc_iou: IoU of two axis-aligned boxes, q0.IOU_LEN result.
// Intersection and union are formed combinationally and captured on start.
// A bit-serial restoring divider then produces one quotient bit per cycle.
module oflow_calc_iou #(
  parameter int COORD_LEN = 11,
  parameter int SIZE_LEN  = 8,
  parameter int IOU_LEN   = 22
) (
  input  logic                   clk,
  input  logic                   reset_N,
  input  logic                   start,
  input  logic [4*COORD_LEN-1:0] bbox_position_frame_k,
  input  logic [4*COORD_LEN-1:0] bbox_position_frame_history,
  input  logic [SIZE_LEN-1:0]    bbox_w_frame_k,
  input  logic [SIZE_LEN-1:0]    bbox_h_frame_k,
  input  logic [SIZE_LEN-1:0]    bbox_w_frame_history,
  input  logic [SIZE_LEN-1:0]    bbox_h_frame_history,
  output logic                   valid_iou,
  output logic [IOU_LEN-1:0]     iou
);

  localparam int INTER_LEN = 2*COORD_LEN;
  localparam int UNION_LEN = 2*SIZE_LEN + 1;
  localparam int REM_LEN   = 2*SIZE_LEN + 2;
  localparam int CMP_LEN   = (INTER_LEN > UNION_LEN) ? INTER_LEN : UNION_LEN;
  localparam int CNT_LEN   = (IOU_LEN > 1) ? $clog2(IOU_LEN) : 1;
  localparam logic [CNT_LEN-1:0] CNT_LAST = CNT_LEN'(IOU_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Unpacked coordinates: index 0 = X_TL, 1 = Y_TL, 2 = X_BR, 3 = Y_BR.
  logic [COORD_LEN-1:0] coord_k [4];
  logic [COORD_LEN-1:0] coord_h [4];
  // Per-axis overlap length: index 0 = x, 1 = y.
  logic [COORD_LEN-1:0] ovl     [2];

  for (genvar gi = 0; gi < 4; gi++) begin : g_unpack
    assign coord_k[gi] = bbox_position_frame_k[(4-gi)*COORD_LEN-1 -: COORD_LEN];
    assign coord_h[gi] = bbox_position_frame_history[(4-gi)*COORD_LEN-1 -: COORD_LEN];
  end

  // Bottom-right coordinates are exclusive, so touching boxes give hi == lo
  // and therefore zero overlap.
  for (genvar gi = 0; gi < 2; gi++) begin : g_axis
    logic [COORD_LEN-1:0] lo;
    logic [COORD_LEN-1:0] hi;
    assign lo      = (coord_k[gi]   > coord_h[gi])   ? coord_k[gi]   : coord_h[gi];
    assign hi      = (coord_k[gi+2] < coord_h[gi+2]) ? coord_k[gi+2] : coord_h[gi+2];
    assign ovl[gi] = (hi > lo) ? (hi - lo) : '0;
  end

  logic [INTER_LEN-1:0] inter_comb;
  logic [UNION_LEN-1:0] area_k;
  logic [UNION_LEN-1:0] area_h;
  logic [UNION_LEN-1:0] union_comb;
  logic                 union_zero;
  logic                 inter_full;

  // Areas come from the size ports, not from the coordinates; union wraps
  // modulo its width when the inputs are inconsistent.
  assign inter_comb = INTER_LEN'(ovl[0]) * INTER_LEN'(ovl[1]);
  assign area_k     = UNION_LEN'(bbox_w_frame_k) * UNION_LEN'(bbox_h_frame_k);
  assign area_h     = UNION_LEN'(bbox_w_frame_history) * UNION_LEN'(bbox_h_frame_history);
  assign union_comb = area_k + area_h - UNION_LEN'(inter_comb);
  assign union_zero = (union_comb == '0);
  assign inter_full = (CMP_LEN'(inter_comb) >= CMP_LEN'(union_comb));

  state_t               state_reg;
  logic [CNT_LEN-1:0]   cnt_reg;
  logic [REM_LEN-1:0]   rem_reg;
  logic [UNION_LEN-1:0] div_reg;
  logic [IOU_LEN-1:0]   quo_reg;
  logic                 spec_reg;
  logic [IOU_LEN-1:0]   spec_val_reg;
  logic [IOU_LEN-1:0]   iou_reg;
  logic                 valid_reg;

  logic [REM_LEN:0]     rem_shift;
  logic                 q_bit;
  logic [REM_LEN-1:0]   rem_next;
  logic [IOU_LEN-1:0]   quo_next;

  // One restoring step: double the remainder, subtract the divisor if it fits.
  assign rem_shift = {rem_reg, 1'b0};
  assign q_bit     = (rem_shift >= (REM_LEN+1)'(div_reg));
  assign rem_next  = q_bit ? REM_LEN'(rem_shift - (REM_LEN+1)'(div_reg))
                           : REM_LEN'(rem_shift);
  assign quo_next  = {quo_reg[IOU_LEN-2:0], q_bit};

  // Control FSM, divider datapath and registered result.
  always_ff @(posedge clk) begin
    if (!reset_N) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      rem_reg      <= '0;
      div_reg      <= '0;
      quo_reg      <= '0;
      spec_reg     <= 1'b0;
      spec_val_reg <= '0;
      iou_reg      <= '0;
      valid_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          valid_reg <= 1'b0;
          if (start) begin
            // Special cases are decided now but still run the full latency.
            state_reg    <= DIV;
            cnt_reg      <= '0;
            quo_reg      <= '0;
            div_reg      <= union_comb;
            spec_reg     <= union_zero | inter_full;
            spec_val_reg <= union_zero ? '0 : '1;
            rem_reg      <= (union_zero | inter_full) ? '0 : REM_LEN'(inter_comb);
          end
        end
        DIV: begin
          rem_reg <= rem_next;
          quo_reg <= quo_next;
          if (cnt_reg == CNT_LAST) begin
            state_reg <= DONE;
            cnt_reg   <= '0;
            iou_reg   <= spec_reg ? spec_val_reg : quo_next;
            valid_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DONE: begin
          state_reg <= IDLE;
          valid_reg <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign valid_iou = valid_reg;
  assign iou       = iou_reg;

endmodule

// File: tb/tb_oflow_calc_iou.sv
// Testbench for oflow_calc_iou: directed steps with a result scoreboard.
`timescale 1ns/1ps
module tb_oflow_calc_iou;

  localparam int C = 11;
  localparam int S = 8;
  localparam int Q = 22;
  localparam int LAT = 23;

  logic           clk = 1'b0;
  logic           reset_N = 1'b0;
  logic           start = 1'b0;
  logic [4*C-1:0] pos_k = '0;
  logic [4*C-1:0] pos_h = '0;
  logic [S-1:0]   wk = '0, hk = '0, wh = '0, hh = '0;
  logic           valid_iou;
  logic [Q-1:0]   iou;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int           pulse_cyc_q[$];
  logic [Q-1:0] pulse_val_q[$];
  int           exp_cyc_q[$];
  logic [Q-1:0] exp_val_q[$];
  string        exp_tag_q[$];

  oflow_calc_iou #(.COORD_LEN(C), .SIZE_LEN(S), .IOU_LEN(Q)) dut (
    .clk                         (clk),
    .reset_N                     (reset_N),
    .start                       (start),
    .bbox_position_frame_k       (pos_k),
    .bbox_position_frame_history (pos_h),
    .bbox_w_frame_k              (wk),
    .bbox_h_frame_k              (hk),
    .bbox_w_frame_history        (wh),
    .bbox_h_frame_history        (hh),
    .valid_iou                   (valid_iou),
    .iou                         (iou)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every result pulse with its cycle number.
  always @(negedge clk) begin
    if (valid_iou === 1'b1) begin
      pulse_cyc_q.push_back(cyc);
      pulse_val_q.push_back(iou);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_boxes(input int kx0, input int ky0, input int kx1, input int ky1,
                           input int hx0, input int hy0, input int hx1, input int hy1,
                           input int kw, input int kh, input int hw, input int hhv);
    pos_k = {C'(kx0), C'(ky0), C'(kx1), C'(ky1)};
    pos_h = {C'(hx0), C'(hy0), C'(hx1), C'(hy1)};
    wk = S'(kw);
    hk = S'(kh);
    wh = S'(hw);
    hh = S'(hhv);
  endtask

  function automatic logic [Q-1:0] model(input int kx0, input int ky0, input int kx1, input int ky1,
                                         input int hx0, input int hy0, input int hx1, input int hy1,
                                         input int kw, input int kh, input int hw, input int hhv);
    longint ox, oy, inter, uni, q;
    ox = longint'((kx1 < hx1) ? kx1 : hx1) - longint'((kx0 > hx0) ? kx0 : hx0);
    oy = longint'((ky1 < hy1) ? ky1 : hy1) - longint'((ky0 > hy0) ? ky0 : hy0);
    if (ox < 0) ox = 0;
    if (oy < 0) oy = 0;
    inter = ox * oy;
    uni = (longint'(kw * kh) + longint'(hw * hhv) - inter) & 64'h1FFFF;
    if (uni == 0) return '0;
    if (inter >= uni) return '1;
    q = (inter <<< Q) / uni;
    return Q'(q);
  endfunction

  // Pulse start for one cycle with the current inputs and book the result.
  task automatic issue(input logic [Q-1:0] exp_val, input string tag);
    start = 1'b1;
    exp_cyc_q.push_back(cyc + LAT);
    exp_val_q.push_back(exp_val);
    exp_tag_q.push_back(tag);
    step();
    start = 1'b0;
  endtask

  // Wait (bounded) for the next pulse and compare it with the oldest booking.
  task automatic wait_result();
    int budget;
    string tag;
    int ecyc;
    logic [Q-1:0] eval;
    budget = 0;
    while (pulse_cyc_q.size() == 0 && budget < 60) begin
      step();
      budget++;
    end
    tag = (exp_tag_q.size() > 0) ? exp_tag_q[0] : "unbooked";
    if (pulse_cyc_q.size() == 0) begin
      check({tag, "_timeout"}, 64'(pulse_cyc_q.size()), 64'd1);
    end else if (exp_cyc_q.size() == 0) begin
      check({tag, "_extra_pulse"}, 64'(exp_cyc_q.size()), 64'd1);
      void'(pulse_cyc_q.pop_front());
      void'(pulse_val_q.pop_front());
    end else begin
      ecyc = exp_cyc_q.pop_front();
      eval = exp_val_q.pop_front();
      void'(exp_tag_q.pop_front());
      check({tag, "_cycle"}, 64'(pulse_cyc_q.pop_front()), 64'(ecyc));
      check({tag, "_iou"}, 64'(pulse_val_q.pop_front()), 64'(eval));
      check({tag, "_hold"}, 64'(iou), 64'(eval));
      $display("txn %s: pulse expected at cycle %0d, iou expected %0d", tag, ecyc, eval);
    end
  endtask

  task automatic no_pulse(input int ncyc, input string tag);
    for (int i = 0; i < ncyc; i++) step();
    check(tag, 64'(pulse_cyc_q.size()), 64'd0);
    pulse_cyc_q.delete();
    pulse_val_q.delete();
  endtask

  initial begin
    int n;
    int kx0, ky0, kw, kh, hx0, hy0, hw, hhv;

    // Reset state.
    reset_N = 1'b0;
    repeat (3) step();
    check("reset_iou", 64'(iou), 64'd0);
    check("reset_valid", 64'(valid_iou), 64'd0);
    reset_N = 1'b1;
    step();

    // Identical boxes saturate.
    set_boxes(0, 0, 10, 10, 0, 0, 10, 10, 10, 10, 10, 10);
    issue(22'h3FFFFF, "identical");
    wait_result();
    no_pulse(2, "identical_single_pulse");

    // Half overlap: 50/150.
    set_boxes(0, 0, 10, 10, 5, 0, 15, 10, 10, 10, 10, 10);
    issue(22'd1398101, "half");
    wait_result();

    // Corner overlap: 25/175.
    set_boxes(0, 0, 10, 10, 5, 5, 15, 15, 10, 10, 10, 10);
    issue(22'd599186, "corner");
    wait_result();

    // Disjoint, touching and zero-size boxes give zero.
    set_boxes(0, 0, 10, 10, 20, 20, 30, 30, 10, 10, 10, 10);
    issue(22'd0, "disjoint");
    wait_result();
    set_boxes(0, 0, 10, 10, 10, 0, 20, 10, 10, 10, 10, 10);
    issue(22'd0, "touching");
    wait_result();
    set_boxes(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(22'd0, "zero_size");
    wait_result();
    no_pulse(2, "zero_size_single_pulse");

    // Consistent random boxes against the reference model.
    for (int i = 0; i < 6; i++) begin
      kx0 = int'($urandom_range(0, 100)); ky0 = int'($urandom_range(0, 100));
      kw  = int'($urandom_range(1, 60));  kh  = int'($urandom_range(1, 60));
      hx0 = int'($urandom_range(0, 100)); hy0 = int'($urandom_range(0, 100));
      hw  = int'($urandom_range(1, 60));  hhv = int'($urandom_range(1, 60));
      set_boxes(kx0, ky0, kx0 + kw, ky0 + kh, hx0, hy0, hx0 + hw, hy0 + hhv, kw, kh, hw, hhv);
      issue(model(kx0, ky0, kx0 + kw, ky0 + kh, hx0, hy0, hx0 + hw, hy0 + hhv, kw, kh, hw, hhv),
            $sformatf("random%0d", i));
      wait_result();
    end

    // Starts while busy and in the DONE cycle are dropped; n+24 is accepted.
    set_boxes(0, 0, 10, 10, 5, 0, 15, 10, 10, 10, 10, 10);
    n = cyc;
    issue(22'd1398101, "busy_first");
    while (cyc < n + 5) step();
    set_boxes(0, 0, 10, 10, 0, 0, 10, 10, 10, 10, 10, 10);
    start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < n + 23) step();
    set_boxes(0, 0, 10, 10, 5, 5, 15, 15, 10, 10, 10, 10);
    start = 1'b1;
    step();
    issue(22'd599186, "busy_second");
    wait_result();
    wait_result();
    no_pulse(3, "busy_no_extra_pulse");

    // Reset mid-operation aborts silently; start during reset is ignored.
    set_boxes(0, 0, 10, 10, 5, 0, 15, 10, 10, 10, 10, 10);
    n = cyc;
    start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < n + 10) step();
    reset_N = 1'b0;
    start = 1'b1;
    step();
    reset_N = 1'b1;
    start = 1'b0;
    check("abort_iou", 64'(iou), 64'd0);
    check("abort_valid", 64'(valid_iou), 64'd0);
    no_pulse(30, "abort_no_pulse");

    set_boxes(0, 0, 10, 10, 5, 5, 15, 15, 10, 10, 10, 10);
    issue(22'd599186, "after_reset");
    wait_result();
    no_pulse(2, "after_reset_single_pulse");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/oflow_calc_iou.md
# oflow_calc_iou

Sequential Intersection-over-Union engine for two axis-aligned bounding boxes: the current-frame box (frame k) and a history box. It sits inside the similarity-metric processing element. The similarity metric pulses `start`, waits for `valid_iou`, and uses `iou` as the IoU term of the weighted score. The division is a bit-serial restoring divider, so each operation has a fixed multi-cycle latency.

## Interface
- `COORD_LEN`, default 11: width of one box coordinate (unsigned pixels).
- `SIZE_LEN`, default 8: width of box width/height inputs (unsigned pixels).
- `IOU_LEN`, default 22: result width, unsigned fraction q0.22.
- `clk`  in  1: single clock, rising edge.
- `reset_N`  in  1: synchronous, active-low reset.
- `start`  in  1: one-cycle request; all box inputs are sampled in the same cycle.
- `bbox_position_frame_k`  in  4*COORD_LEN: {X_TL, Y_TL, X_BR, Y_BR}; X_TL in the MSBs, Y_BR in the LSBs.
- `bbox_position_frame_history`  in  4*COORD_LEN: same packing, history box.
- `bbox_w_frame_k`, `bbox_h_frame_k`  in  SIZE_LEN each: frame-k box width and height.
- `bbox_w_frame_history`, `bbox_h_frame_history`  in  SIZE_LEN each: history box width and height.
- `valid_iou`  out  1: one-cycle pulse; `iou` holds the new result in this cycle.
- `iou`  out  IOU_LEN: registered IoU result, q0.22.

## Operation
- Intersection terms:
  - ox = min(X_BR_k, X_BR_h) − max(X_TL_k, X_TL_h), clamped to 0 when the difference is ≤ 0. Coordinates are exclusive, so boxes that only touch have zero overlap.
  - oy is computed the same way on Y.
  - inter = ox*oy, width 2*COORD_LEN.
- Union: union = w_k*h_k + w_h*h_h − inter, with width 2*SIZE_LEN+1. Areas come from the width/height ports, not from the coordinates.
- Both inter and union are computed combinationally from the inputs and registered on the `start` edge. Later input changes do not affect the running operation.
- Special cases:
  - union == 0: the result is 0.
  - inter ≥ union (identical boxes, or inconsistent inputs): the result is all ones, 0x3FFFFF.
  - Otherwise iou = floor(inter·2^IOU_LEN / union), computed exactly.
- Divider: restoring, one quotient bit per cycle, MSB first.
  - Remainder register is 2*SIZE_LEN+2 bits and starts at inter.
  - Each step: r ← 2r; if r ≥ union, set the quotient bit to 1 and r ← r − union.
  - The special cases are resolved on the `start` edge and still take the full latency.
- States:
  - IDLE: waits for `start`.
  - DIV: exactly IOU_LEN cycles, bit counter runs 0..IOU_LEN−1.
  - DONE: one cycle, returns to IDLE.
- `iou` loads the final quotient on the DIV→DONE edge. It holds that value until the next completion.
- `start` is ignored outside IDLE; there is no queuing.

## Timing
- `start` is high in cycle n, so it is sampled at the end of cycle n:
  - DIV occupies cycles n+1 … n+22.
  - DONE, with `valid_iou` = 1, occurs in cycle n+23.
  - The block is back in IDLE in cycle n+24.
- Fixed latency: 23 cycles from the `start` cycle to the `valid_iou` cycle.
- Back-to-back: a new `start` is accepted in cycle n+24 at the earliest. A `start` in the DONE cycle is dropped.
- `valid_iou` is decoded from state DONE and is exactly one cycle wide.
- Reset (`reset_N` = 0 at a rising edge), including mid-operation:
  - State goes to IDLE and the counter clears.
  - `iou` = 0 and `valid_iou` = 0 from the next cycle.
  - The aborted operation produces no pulse.
  - `start` sampled together with an active reset is ignored.

## Test plan
- Identical boxes (0,0,10,10), w=h=10 on both sides → `valid_iou` in cycle n+23, iou = 0x3FFFFF.
- Half overlap: k=(0,0,10,10), h=(5,0,15,10), all sizes 10 → inter=50, union=150, iou = 0x155555 (1398101).
- Corner overlap: k=(0,0,10,10), h=(5,5,15,15), all sizes 10 → inter=25, union=175, iou = 599186.
- Disjoint (0,0,10,10) / (20,20,30,30) and touching (0,0,10,10) / (10,0,20,10) → iou = 0. Both-zero-size boxes → iou = 0, still a single `valid_iou` at n+23.
- Change inputs and pulse `start` again in cycles n+5 and n+23 → both are ignored, the result matches the original inputs, and exactly one pulse occurs. A new `start` at n+24 → its result pulses at n+47.
- Assert `reset_N`=0 in cycle n+10 → no `valid_iou`, iou = 0. A fresh `start` after release completes normally with correct latency.
